// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: signal bundle between sample source, FFT core, display and the sequencer
//   sample_in/sample_valid : audio stream into the sequencer
//   t_bus/fft_start        : frame and start strobe towards the FFT core
//   fft_done/f_bus         : completion and spectrum back from the FFT core
//   spec_out/spec_valid    : captured spectrum towards the display
//   busy/overrun/timeout_err/clr_status : status and status clear
//   modport slave  : the sequencer's view
//   modport master : the surrounding system's view
interface fft_frame_sequencer_if #(parameter int N_PTS = 16, parameter int DW = 16);
  logic [DW-1:0]       sample_in;
  logic                sample_valid;
  logic [N_PTS*DW-1:0] t_bus;
  logic                fft_start;
  logic                fft_done;
  logic [N_PTS*DW-1:0] f_bus;
  logic [N_PTS*DW-1:0] spec_out;
  logic                spec_valid;
  logic                busy;
  logic                overrun;
  logic                timeout_err;
  logic                clr_status;
  modport master (
    output sample_in, sample_valid, fft_done, f_bus, clr_status,
    input  t_bus, fft_start, spec_out, spec_valid, busy, overrun, timeout_err
  );
  modport slave (
    input  sample_in, sample_valid, fft_done, f_bus, clr_status,
    output t_bus, fft_start, spec_out, spec_valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: frames an audio stream into N_PTS blocks (ping-pong banks) and sequences an FFT core
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fft_frame_sequencer_if.slave (samples in, t_bus/fft_start out, fft_done/f_bus in,
//           spec_out/spec_valid/busy/overrun/timeout_err out, clr_status in)
//   Optional: define FFT_INPUT_CLIP_EN to saturate samples to [CLIP_MIN, CLIP_MAX] before storage.
module fft_frame_sequencer #(
  parameter int N_PTS    = 16,
  parameter int DW       = 16,
  parameter int TIMEOUT  = 64,
  parameter int CLIP_MAX = 511,
  parameter int CLIP_MIN = -512
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_frame_sequencer_if.slave bus
);
  localparam int CW = $clog2(N_PTS);
  localparam int TW = $clog2(TIMEOUT);
`ifdef FFT_INPUT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
  state_t              state;
  logic [N_PTS*DW-1:0] bank [2];
  logic [1:0]          pend;
  logic                fill, cur, done_q;
  logic [CW-1:0]       wr_cnt;
  logic [TW-1:0]       tmo_cnt;
  logic [DW-1:0]       wdata;
  logic                done_rise, tmo, rel, other_busy, last, push, drop;
  assign wdata = (CLIP_EN && $signed(bus.sample_in) > CLIP_MAX) ? DW'(CLIP_MAX) :
                 (CLIP_EN && $signed(bus.sample_in) < CLIP_MIN) ? DW'(CLIP_MIN) : bus.sample_in;
  assign done_rise  = bus.fft_done && !done_q;
  assign tmo        = state == WAIT && !done_rise && tmo_cnt == TW'(TIMEOUT - 1);
  // a bank being released this cycle already counts as free for the fill side
  assign rel        = state == CAPTURE || tmo;
  assign other_busy = pend[~fill] || (state != IDLE && cur == ~fill && !rel);
  assign last       = bus.sample_valid && wr_cnt == CW'(N_PTS - 1);
  assign push       = last && !other_busy;
  assign drop       = last && other_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill   <= 1'b0;
      wr_cnt <= '0;
    end else if (bus.sample_valid) begin
      wr_cnt <= last ? '0 : wr_cnt + 1'b1;
      fill   <= push ? ~fill : fill;
    end
  always_ff @(posedge clk)
    if (bus.sample_valid) bank[fill][int'(wr_cnt)*DW +: DW] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      pend            <= '0;
      cur             <= 1'b0;
      done_q          <= 1'b0;
      tmo_cnt         <= '0;
      bus.t_bus       <= '0;
      bus.fft_start   <= 1'b0;
      bus.spec_out    <= '0;
      bus.spec_valid  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.overrun     <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      done_q          <= bus.fft_done;
      bus.fft_start   <= 1'b0;
      bus.spec_valid  <= 1'b0;
      bus.overrun     <= drop || (bus.overrun && !bus.clr_status);
      bus.timeout_err <= tmo || (bus.timeout_err && !bus.clr_status);
      // at most one bank is ever pending, so IDLE can clear both flags when it takes one
      pend <= (state == IDLE ? 2'b00 : pend) | (push ? (fill ? 2'b10 : 2'b01) : 2'b00);
      case (state)
        IDLE:
          if (|pend) begin
            state         <= START;
            cur           <= pend[1];
            bus.t_bus     <= bank[pend[1]];
            bus.fft_start <= 1'b1;
            bus.busy      <= 1'b1;
          end
        START: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT:
          if (done_rise) state <= CAPTURE;
          else if (tmo) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else tmo_cnt <= tmo_cnt + 1'b1;
        CAPTURE: begin
          state          <= IDLE;
          bus.spec_out   <= bus.f_bus;
          bus.spec_valid <= 1'b1;
          bus.busy       <= 1'b0;
        end
      endcase
    end
endmodule
